// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter family.
//   state_e        : arbiter FSM states (idle, tag emission, packet streaming)
//   grant_w()      : width of a port index for n requesters (never below 1)
//   TagBaseDefault : default first tag byte value
package uart_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StTag    = 2'd1,
    StStream = 2'd2
  } state_e;

  localparam logic [7:0] TagBaseDefault = 8'h30;

  function automatic int unsigned grant_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Searches ptr_i+1, ptr_i+2, ... (mod N) and returns the first set bit of valid_i.
//   valid_i [N-1:0] : request vector
//   ptr_i   [W-1:0] : index of the most recently served requester
//   found_o         : at least one request is set
//   idx_o   [W-1:0] : winning index (0 when nothing is found)
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = grant_w(N)
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    int unsigned cand;
    found_o = 1'b0;
    idx_o   = '0;
    // Offset N wraps back to ptr_i itself, so it is searched last.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(ptr_i) + i) % N;
      if (!found_o && valid_i[cand]) begin
        found_o = 1'b1;
        idx_o   = W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART TX input between N_PORTS requesters.
// Round-robin arbitration with packet lock: the granted port keeps the
// transmitter until it sends a byte flagged last or MAX_BURST bytes have gone.
// A single registered stage drives the valid/ready interface of the TX core.
//
// Ports:
//   sys_clk, sys_rst     : clock, asynchronous active-high reset
//   req_data/valid/last  : per-port byte, valid and end-of-packet flag
//   req_ready            : per-port accept (one-hot or zero)
//   tx_data/tx_valid     : registered byte toward the UART TX core
//   tx_ready             : TX core accepts the byte
//   grant_id             : currently or most recently granted port
//   busy                 : FSM not idle, or a byte is still held in the output stage
//
// Optional feature: define UART_TX_ARBITER_TAG_EN to emit a tag byte
// (TAG_BASE + grant_id) at the start of every grant.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned MAX_BURST = 64,
  parameter logic [7:0]  TAG_BASE  = TagBaseDefault,
  localparam int unsigned GrantW   = grant_w(N_PORTS)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [8*N_PORTS-1:0] req_data,
  input  logic [N_PORTS-1:0]   req_valid,
  input  logic [N_PORTS-1:0]   req_last,
  output logic [N_PORTS-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [GrantW-1:0]    grant_id,
  output logic                 busy
);

  if (N_PORTS < 2 || N_PORTS > 8) begin : g_bad_ports
    $error("uart_tx_arbiter: N_PORTS must be 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("uart_tx_arbiter: MAX_BURST must be 1..255");
  end
  // Tag bytes must not wrap past 8'hFF.
  if (32'(TAG_BASE) + N_PORTS - 1 > 255) begin : g_bad_tag
    $error("uart_tx_arbiter: TAG_BASE + N_PORTS - 1 exceeds 8 bits");
  end

  state_e            state_q, state_d;
  logic [GrantW-1:0] grant_q, grant_d;
  logic [GrantW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;

  logic              pick_found;
  logic [GrantW-1:0] pick_idx;
  logic              load_en;
  logic [7:0]        burst_inc;

  rr_pick #(
    .N (N_PORTS),
    .W (GrantW)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign load_en   = !tx_valid_q || tx_ready;
  assign burst_inc = burst_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    tx_data_d   = tx_data_q;
    // A byte taken by the core empties the stage unless something reloads it.
    tx_valid_d  = tx_valid_q && !tx_ready;
    req_ready   = '0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          burst_cnt_d = '0;
`ifdef UART_TX_ARBITER_TAG_EN
          state_d     = StTag;
`else
          state_d     = StStream;
`endif
        end
      end

`ifdef UART_TX_ARBITER_TAG_EN
      StTag: begin
        if (load_en) begin
          tx_data_d  = TAG_BASE + 8'(grant_q);
          tx_valid_d = 1'b1;
          state_d    = StStream;
        end
      end
`endif

      StStream: begin
        req_ready[grant_q] = load_en;
        // A dropped valid simply stalls here: the grant is held until the packet ends.
        if (load_en && req_valid[grant_q]) begin
          tx_data_d   = req_data[8*grant_q +: 8];
          tx_valid_d  = 1'b1;
          burst_cnt_d = burst_inc;
          if (req_last[grant_q] || burst_inc == 8'(MAX_BURST)) begin
            rr_ptr_d = grant_q;
            state_d  = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= GrantW'(N_PORTS - 1);
      burst_cnt_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle) || tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_PORTS=4, MAX_BURST=4).
// Per-port source queues feed the DUT; a monitor collects every byte the TX
// core accepts and the expected stream is built by hand for each scenario.
module tb_uart_tx_arbiter;

  localparam int unsigned NPorts = 4;
`ifdef UART_TX_ARBITER_TAG_EN
  localparam bit TagEn = 1'b1;
`else
  localparam bit TagEn = 1'b0;
`endif

  logic          clk;
  logic          sys_rst;
  logic [31:0]   req_data;
  logic [3:0]    req_valid;
  logic [3:0]    req_last;
  logic [3:0]    req_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [1:0]    grant_id;
  logic          busy;

  int            n_checks;
  int            n_errs;
  logic [8:0]    src_q [NPorts][$];
  logic [7:0]    got_q [$];
  logic [7:0]    exp_q [$];
  bit            toggle_en;

  uart_tx_arbiter #(
    .N_PORTS   (NPorts),
    .MAX_BURST (4),
    .TAG_BASE  (8'h30)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int p, input logic [7:0] d, input bit l);
    src_q[p].push_back({l, d});
  endtask

  task automatic exp_grant(input int p);
    if (TagEn) exp_q.push_back(8'h30 + 8'(p));
  endtask

  task automatic exp_byte(input logic [7:0] d);
    exp_q.push_back(d);
  endtask

  function automatic bit srcs_empty();
    bit e = 1'b1;
    for (int p = 0; p < NPorts; p++) if (src_q[p].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 500 && !done; k++) begin
      if (srcs_empty() && req_valid == '0 && !busy) done = 1'b1;
      else @(negedge clk);
    end
    check_eq({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 sys_rst = 1'b1;
    for (int p = 0; p < NPorts; p++) src_q[p].delete();
    @(negedge clk);
    #2 sys_rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // Source driver: presents queue heads; pops a byte accepted at the previous edge.
  initial begin
    logic [3:0] acc;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NPorts; p++) begin
        if (acc[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
        if (src_q[p].size() != 0) begin
          req_valid[p]       = 1'b1;
          req_last[p]        = src_q[p][0][8];
          req_data[8*p +: 8] = src_q[p][0][7:0];
        end else begin
          req_valid[p]       = 1'b0;
          req_last[p]        = 1'b0;
          req_data[8*p +: 8] = 8'h00;
        end
      end
    end
  end

  // TX core ready: steady 1, or toggling every cycle when enabled.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) tx_ready = ~tx_ready;
      else tx_ready = 1'b1;
    end
  end

  // Monitor: collects delivered bytes and checks stability under back-pressure.
  initial begin
    bit         stall;
    logic [7:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (sys_rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check_eq("tx_hold_valid", 32'(tx_valid), 32'd1);
          check_eq("tx_hold_data", 32'(tx_data), 32'(held));
        end
        check_eq("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (tx_valid && tx_ready) got_q.push_back(tx_data);
        stall = tx_valid && !tx_ready;
        held  = tx_data;
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_errs    = 0;
    toggle_en = 1'b0;
    sys_rst   = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'h00);
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    #2 sys_rst = 1'b0;

    // Single port 0: 41 42 43(last), one cycle latency per byte
    @(negedge clk);
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    exp_grant(0);
    exp_byte(8'h41);
    exp_byte(8'h42);
    exp_byte(8'h43);
    if (!TagEn) begin
      @(negedge clk);
      check_eq("t1_decide_ready", 32'(req_ready), 32'h0);
      check_eq("t1_decide_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check_eq("t1_stream_ready", 32'(req_ready), 32'h1);
      check_eq("t1_no_tx_yet", 32'(tx_valid), 32'd0);
      @(negedge clk);
      check_eq("t1_tx0_valid", 32'(tx_valid), 32'd1);
      check_eq("t1_tx0_data", 32'(tx_data), 32'h41);
      @(negedge clk);
      check_eq("t1_tx1_data", 32'(tx_data), 32'h42);
      @(negedge clk);
      check_eq("t1_tx2_data", 32'(tx_data), 32'h43);
      check_eq("t1_busy_hold", 32'(busy), 32'd1);
      check_eq("t1_grant", 32'(grant_id), 32'd0);
      @(negedge clk);
      check_eq("t1_tx_done", 32'(tx_valid), 32'd0);
      check_eq("t1_busy_fall", 32'(busy), 32'd0);
    end
    wait_idle("t1");
    compare_stream("t1");

    // Ports 0,1,2 two-byte packets all at once: order 0,1,2
    do_reset();
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      push(p, 8'(p * 16), 1'b0);
      push(p, 8'(p * 16 + 1), 1'b1);
      exp_grant(p);
      exp_byte(8'(p * 16));
      exp_byte(8'(p * 16 + 1));
    end
    wait_idle("t2");
    compare_stream("t2");
    check_eq("t2_grant", 32'(grant_id), 32'd2);
    // rr_ptr=2 now: port 0 beats port 2
    @(negedge clk);
    push(2, 8'h23, 1'b1);
    push(0, 8'h03, 1'b1);
    exp_grant(0);
    exp_byte(8'h03);
    exp_grant(2);
    exp_byte(8'h23);
    wait_idle("t2b");
    compare_stream("t2b");

    // MAX_BURST=4: port 1 streams 10 bytes, port 3 waiting
    @(negedge clk);
    for (int i = 0; i < 10; i++) push(1, 8'(8'h10 + i), i == 9);
    repeat (3) @(negedge clk);
    push(3, 8'h30, 1'b0);
    push(3, 8'h31, 1'b1);
    exp_grant(1);
    for (int i = 0; i < 4; i++) exp_byte(8'(8'h10 + i));
    exp_grant(3);
    exp_byte(8'h30);
    exp_byte(8'h31);
    exp_grant(1);
    for (int i = 4; i < 8; i++) exp_byte(8'(8'h10 + i));
    exp_grant(1);
    exp_byte(8'h18);
    exp_byte(8'h19);
    wait_idle("t3");
    compare_stream("t3");
    check_eq("t3_grant", 32'(grant_id), 32'd1);

    // tx_ready toggling during a 5-byte packet from port 2
    @(negedge clk);
    toggle_en = 1'b1;
    for (int i = 0; i < 5; i++) push(2, 8'(8'h20 + i), i == 4);
    exp_grant(2);
    for (int i = 0; i < 4; i++) exp_byte(8'(8'h20 + i));
    exp_grant(2);
    exp_byte(8'h24);
    wait_idle("t4");
    toggle_en = 1'b0;
    repeat (2) @(negedge clk);
    compare_stream("t4");

    // Reset in the middle of a packet from port 0
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(0, 8'(8'h40 + i), i == 3);
    repeat (4) @(negedge clk);
    #2 sys_rst = 1'b1;
    #1;
    check_eq("t5_rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("t5_rst_req_ready", 32'(req_ready), 32'h0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_grant", 32'(grant_id), 32'd0);
    for (int p = 0; p < NPorts; p++) src_q[p].delete();
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    #2 sys_rst = 1'b0;
    @(negedge clk);
    push(3, 8'h3A, 1'b1);
    push(0, 8'h0A, 1'b1);
    exp_grant(0);
    exp_byte(8'h0A);
    exp_grant(3);
    exp_byte(8'h3A);
    wait_idle("t5");
    compare_stream("t5");

    // Port 2 single byte 0x55: tag 0x32 precedes it only when tagging is built in
    @(negedge clk);
    push(2, 8'h55, 1'b1);
    exp_grant(2);
    exp_byte(8'h55);
    wait_idle("t6");
    compare_stream("t6");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
